fft_frame_sequencer: RTL and testbench

Read-side controller for the ping-pong sample buffer. It queues each "buffer full" event from the ping-pong RAM and streams the filled bank out as a framed sample stream to the FFT core. It sequences bank select and read addresses against the RAM's one-cycle synchronous read, absorbs FFT backpressure, and flags frames lost because the reader fell behind. It sits between the ping-pong RAM and the FFT input.

---
 rtl/fft_frame_sequencer.sv | 114 +++++++++++
 tb/tb_fft_frame_sequencer.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_sequencer.sv
// fft_frame_sequencer: queues ping-pong bank-full events (buffer_ready_i/bank_i), reads the bank via rd_en_o/rd_bank_o/rd_addr_o/rd_data_i, streams it framed to the FFT (fft_*), reports frame_done_o/busy_o/overrun_o/frame_count_o
module fft_frame_sequencer #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             buffer_ready_i,
  input  logic             bank_i,
  output logic             rd_en_o,
  output logic             rd_bank_o,
  output logic [AW-1:0]    rd_addr_o,
  input  logic [WIDTH-1:0] rd_data_i,
  output logic [WIDTH-1:0] fft_data_o,
  output logic             fft_valid_o,
  input  logic             fft_ready_i,
  output logic             fft_sof_o,
  output logic             fft_eof_o,
  output logic             frame_done_o,
  output logic             busy_o,
  output logic             overrun_o,
  output logic [15:0]      frame_count_o
);
  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;
  localparam int EW = WIDTH + 2;
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  state_t state_q, state_d;
  logic pend_v_q, pend_v_d, pend_bank_q, pend_bank_d, bank_q, bank_d;
  logic overrun_q, overrun_d, done_q, done_d;
  logic in_v_q, in_v_d, in_sof_q, in_sof_d, in_eof_q, in_eof_d;
  logic out_v_q, out_v_d, skid_v_q, skid_v_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [15:0] count_q, count_d;
  logic [EW-1:0] out_q, out_d, skid_q, skid_d, in_e, head;
  logic xfer, consume;
  assign in_e = {in_sof_q, in_eof_q, rd_data_i};
  assign head = out_v_q ? out_q : (in_v_q ? in_e : '0);
  assign {fft_sof_o, fft_eof_o, fft_data_o} = head;
  assign fft_valid_o = out_v_q | in_v_q;
  assign xfer = fft_valid_o & fft_ready_i;
  assign consume = (state_q == IDLE) & pend_v_q;
  assign rd_en_o = (state_q == READ) && (3'(out_v_q) + 3'(skid_v_q) + 3'(in_v_q) <= 3'd1 + 3'(xfer));
  assign rd_bank_o = bank_q;
  assign rd_addr_o = addr_q;
  assign frame_done_o = done_q;
  assign busy_o = state_q != IDLE;
  assign overrun_o = overrun_q;
  assign frame_count_o = count_q;
  always_comb begin
    pend_v_d = buffer_ready_i | (pend_v_q & ~consume);
    pend_bank_d = buffer_ready_i ? bank_i : pend_bank_q;
    overrun_d = overrun_q | (buffer_ready_i & pend_v_q & ~consume);
    bank_d = consume ? pend_bank_q : bank_q;
    addr_d = consume ? '0 : (rd_en_o && addr_q != LAST) ? addr_q + 1'b1 : addr_q;
    in_v_d = rd_en_o;
    in_sof_d = rd_en_o & (addr_q == '0);
    in_eof_d = rd_en_o & (addr_q == LAST);
    done_d = (state_q == DRAIN) & xfer & fft_eof_o;
    count_d = count_q + 16'(done_d);
    state_d = consume ? READ : (rd_en_o && addr_q == LAST) ? DRAIN : done_d ? IDLE : state_q;
    out_v_d = out_v_q;
    out_d = out_q;
    skid_v_d = skid_v_q;
    skid_d = skid_q;
    if (!out_v_q) begin
      out_v_d = in_v_q & ~xfer;
      out_d = in_e;
    end else if (xfer) begin
      out_v_d = skid_v_q | in_v_q;
      out_d = skid_v_q ? skid_q : in_e;
      skid_v_d = skid_v_q & in_v_q;
      skid_d = in_e;
    end else if (in_v_q) begin
      skid_v_d = 1'b1;
      skid_d = in_e;
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      pend_v_q <= 1'b0;
      pend_bank_q <= 1'b0;
      bank_q <= 1'b0;
      overrun_q <= 1'b0;
      done_q <= 1'b0;
      in_v_q <= 1'b0;
      in_sof_q <= 1'b0;
      in_eof_q <= 1'b0;
      out_v_q <= 1'b0;
      skid_v_q <= 1'b0;
      addr_q <= '0;
      count_q <= '0;
      out_q <= '0;
      skid_q <= '0;
    end else begin
      state_q <= state_d;
      pend_v_q <= pend_v_d;
      pend_bank_q <= pend_bank_d;
      bank_q <= bank_d;
      overrun_q <= overrun_d;
      done_q <= done_d;
      in_v_q <= in_v_d;
      in_sof_q <= in_sof_d;
      in_eof_q <= in_eof_d;
      out_v_q <= out_v_d;
      skid_v_q <= skid_v_d;
      addr_q <= addr_d;
      count_q <= count_d;
      out_q <= out_d;
      skid_q <= skid_d;
    end
  end
endmodule

// File: tb/tb_fft_frame_sequencer.sv
// tb_fft_frame_sequencer: directed and randomized frames checked against a frame-level stream model
module tb_fft_frame_sequencer;
  localparam int W = 16;
  localparam int D = 8;
  localparam int A = 3;
  logic clk = 0, rst = 1, br = 0, bk = 0, rdy = 0;
  logic rd_en, rd_bank, fft_valid, sof, eof, done, busy, overrun;
  logic [A-1:0] rd_addr;
  logic [W-1:0] rd_data = '0, fft_data;
  logic [15:0] fcount;
  int vectors = 0, miscompares = 0;
  always #5 clk = ~clk;
  fft_frame_sequencer #(.WIDTH(W), .DEPTH(D), .AW(A)) dut (
    .clk_i(clk), .rst_i(rst), .buffer_ready_i(br), .bank_i(bk),
    .rd_en_o(rd_en), .rd_bank_o(rd_bank), .rd_addr_o(rd_addr), .rd_data_i(rd_data),
    .fft_data_o(fft_data), .fft_valid_o(fft_valid), .fft_ready_i(rdy),
    .fft_sof_o(sof), .fft_eof_o(eof), .frame_done_o(done), .busy_o(busy),
    .overrun_o(overrun), .frame_count_o(fcount)
  );
  function automatic logic [W-1:0] ram(input logic b, input int a);
    return (b ? 16'h100 : 16'h200) + 16'(a);
  endfunction
  always @(posedge clk) if (rd_en) rd_data <= ram(rd_bank, int'(rd_addr));
  logic [W-1:0] log_d [512];
  logic log_s [512], log_e [512], log_b [512];
  int log_c [512];
  int nx = 0, nd = 0, cyc_n = 0, outst = 0, occ_max = 0, stab_err = 0;
  logic pv = 0, pr = 0, ps = 0, pe = 0;
  logic [W-1:0] pd = '0;
  always @(negedge clk) begin
    cyc_n++;
    if (rst) begin
      outst = 0;
      pv = 0;
    end else begin
      if (pv && !pr && (!fft_valid || fft_data !== pd || sof !== ps || eof !== pe)) stab_err++;
      if (fft_valid && rdy && nx < 512) begin
        log_d[nx] = fft_data;
        log_s[nx] = sof;
        log_e[nx] = eof;
        log_b[nx] = rd_bank;
        log_c[nx] = cyc_n;
        nx++;
      end
      outst = outst + int'(rd_en) - int'(fft_valid && rdy);
      if (outst > occ_max) occ_max = outst;
      if (done) nd++;
      pv = fft_valid;
      pr = rdy;
      pd = fft_data;
      ps = sof;
      pe = eof;
    end
  end
  logic exp_b [$];
  int m_frames = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tk(input logic b_r, input logic b_k, input logic r);
    @(posedge clk);
    #2;
    br = b_r;
    bk = b_k;
    rdy = r;
    #1;
  endtask
  task automatic wait_done(input int target, input int pct);
    for (int i = 0; i < 400 && nd < target; i++) tk(1'b0, 1'b0, $urandom_range(0, 99) < pct);
    chk("done_count", nd, target);
  endtask
  task automatic check_stream(input int base, input int nf);
    chk("stream_len", nx - base, nf * D);
    for (int k = 0; k < nf * D && base + k < 512; k++) begin
      int i;
      logic b;
      i = k % D;
      b = exp_b[k / D];
      chk("stream", {log_s[base+k], log_e[base+k], log_b[base+k], log_d[base+k]},
          {i == 0, i == D - 1, b, ram(b, i)});
    end
  endtask
  initial begin
    int base, n0, gap;
    logic b;
    repeat (3) tk(1'b0, 1'b0, 1'b0);
    chk("reset_outs", {rd_en, rd_bank, rd_addr, fft_valid, sof, eof, done, busy, overrun, fcount}, 0);
    chk("reset_data", fft_data, 0);
    rst = 0;
    tk(1'b0, 1'b0, 1'b1);
    tk(1'b1, 1'b1, 1'b1);
    chk("c0_busy", busy, 0);
    tk(1'b0, 1'b0, 1'b1);
    chk("c1_busy", {busy, rd_en}, 0);
    tk(1'b0, 1'b0, 1'b1);
    chk("c2_read", {busy, rd_en, rd_bank, rd_addr}, {1'b1, 1'b1, 1'b1, 3'd0});
    for (int c = 3; c <= D + 2; c++) begin
      tk(1'b0, 1'b0, 1'b1);
      chk("timed_out", {fft_valid, sof, eof, fft_data}, {1'b1, c == 3, c == D + 2, ram(1'b1, c - 3)});
    end
    tk(1'b0, 1'b0, 1'b1);
    m_frames = 1;
    chk("c11_done", {done, busy, fcount}, {1'b1, 1'b0, 16'(m_frames)});
    tk(1'b0, 1'b0, 1'b1);
    chk("done_pulse", done, 0);
    exp_b = '{1'b0};
    base = nx;
    n0 = nd;
    tk(1'b1, 1'b0, $urandom_range(0, 99) < 30);
    wait_done(n0 + 1, 30);
    check_stream(base, 1);
    m_frames++;
    exp_b = '{1'b1, 1'b0};
    base = nx;
    n0 = nd;
    tk(1'b1, 1'b1, 1'b1);
    repeat (3) tk(1'b0, 1'b0, 1'b1);
    tk(1'b1, 1'b0, 1'b1);
    wait_done(n0 + 2, 100);
    check_stream(base, 2);
    gap = log_c[base+D] - log_c[base+D-1] - 1;
    chk("bubble", gap, 2);
    chk("b2b_overrun", overrun, 0);
    m_frames += 2;
    chk("b2b_count", fcount, m_frames);
    exp_b = '{1'b1, 1'b1};
    base = nx;
    n0 = nd;
    tk(1'b1, 1'b1, 1'b0);
    repeat (3) tk(1'b0, 1'b0, 1'b0);
    tk(1'b1, 1'b0, 1'b0);
    tk(1'b0, 1'b0, 1'b0);
    tk(1'b1, 1'b1, 1'b0);
    wait_done(n0 + 2, 30);
    check_stream(base, 2);
    chk("overrun_set", overrun, 1);
    m_frames += 2;
    chk("ovr_count", fcount, m_frames);
    tk(1'b1, 1'b0, 1'b1);
    repeat (7) tk(1'b0, 1'b0, 1'b1);
    rst = 1;
    tk(1'b0, 1'b0, 1'b1);
    chk("midrst_outs", {rd_en, rd_bank, rd_addr, fft_valid, sof, eof, done, busy, overrun, fcount}, 0);
    chk("midrst_data", fft_data, 0);
    rst = 0;
    m_frames = 0;
    exp_b = '{1'b1};
    base = nx;
    n0 = nd;
    tk(1'b1, 1'b1, 1'b1);
    wait_done(n0 + 1, 100);
    check_stream(base, 1);
    m_frames++;
    chk("post_rst_count", fcount, m_frames);
    exp_b = '{1'b0, 1'b1};
    base = nx;
    n0 = nd;
    tk(1'b1, 1'b0, 1'b1);
    tk(1'b1, 1'b1, 1'b1);
    wait_done(n0 + 2, 100);
    check_stream(base, 2);
    chk("same_cycle_overrun", overrun, 0);
    m_frames += 2;
    repeat (4) begin
      b = 1'($urandom_range(0, 1));
      exp_b = '{b};
      base = nx;
      n0 = nd;
      tk(1'b1, b, $urandom_range(0, 1) == 1);
      wait_done(n0 + 1, int'($urandom_range(20, 90)));
      check_stream(base, 1);
      m_frames++;
    end
    chk("final_count", fcount, m_frames);
    chk("hold_stable_errs", stab_err, 0);
    chk("occupancy_le2", occ_max <= 2, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
